// File: rtl/crc32_fcs_stream.sv
// Streaming Ethernet CRC-32 engine: appends the FCS on transmit or checks the residue on receive.
// BYTES lanes per beat, lane 0 first on the wire, with a single registered output stage.
//
// state   | meaning
// S_IDLE  | between frames, passing beats through
// S_DATA  | inside a frame, passing beats through
// S_FCS   | APPEND only: emitting the latched FCS, input blocked
module crc32_fcs_stream #(
  parameter int          BYTES   = 1,
  parameter bit          MODE    = 1'b0,
  parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
  parameter logic [31:0] XOROUT  = 32'hFFFF_FFFF,
  parameter logic [31:0] RESIDUE = 32'hC704_DD7B
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               crc_clr,
  input  logic [8*BYTES-1:0] s_data,
  input  logic [BYTES-1:0]   s_keep,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [8*BYTES-1:0] m_data,
  output logic [BYTES-1:0]   m_keep,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic [31:0]        crc_out,
  output logic               crc_valid,
  output logic               crc_err
);

  localparam int          W     = 8 * BYTES;
  localparam int          NBEAT = 4 / BYTES;
  localparam logic [31:0] POLY  = 32'h04C1_1DB7;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FCS} state_t;

  state_t           state;
  logic [31:0]      crc_reg;
  logic [31:0]      crc_next;
  logic [31:0]      crc_fin;
  logic [31:0]      fcs;
  logic [1:0]       cnt;
  logic [BYTES-1:0] lane_en;
  logic             accept;

  // Feeding d[0] first into the MSB-first register is the same as bit-reversing the byte.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] crc_beat(input logic [31:0] c, input logic [W-1:0] d,
                                           input logic [BYTES-1:0] en);
    logic [31:0] r;
    r = c;
    for (int l = 0; l < BYTES; l++)
      if (en[l]) r = crc_byte(r, d[8*l +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  assign s_ready = (!m_valid || m_ready) && (state != S_FCS);
  assign accept  = s_valid && s_ready;

  always_comb begin
    lane_en  = s_last ? s_keep : '1;
    crc_next = crc_beat(crc_reg, s_data, lane_en);
    crc_fin  = bitrev32(crc_next) ^ XOROUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      crc_reg   <= INIT;
      fcs       <= '0;
      cnt       <= '0;
      m_data    <= '0;
      m_keep    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      case (state)
        S_FCS: begin
          if (!m_valid || m_ready) begin
            if (crc_clr) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              m_data  <= fcs[W-1:0];
              fcs     <= fcs >> W;
              m_keep  <= '1;
              m_valid <= 1'b1;
              m_last  <= (cnt == 2'd0);
              if (cnt == 2'd0) state <= S_IDLE;
              else             cnt   <= cnt - 2'd1;
            end
          end else if (crc_clr) begin
            // the beat already on m_* still completes; later FCS beats are dropped
            state <= S_IDLE;
          end
          if (crc_clr) crc_reg <= INIT;
        end
        default: begin
          if (accept) begin
            m_data  <= s_data;
            m_keep  <= lane_en;
            m_valid <= 1'b1;
            m_last  <= MODE && s_last;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
          if (crc_clr) begin
            crc_reg <= INIT;
            state   <= S_IDLE;
          end else if (accept) begin
            if (s_last) begin
              crc_reg   <= INIT;
              crc_out   <= crc_fin;
              crc_valid <= 1'b1;
              if (MODE) begin
                crc_err <= (crc_next != RESIDUE);
                state   <= S_IDLE;
              end else begin
                fcs   <= crc_fin;
                cnt   <= 2'(NBEAT - 1);
                state <= S_FCS;
              end
            end else begin
              crc_reg <= crc_next;
              state   <= S_DATA;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_fcs_stream.sv
// Scoreboard bench for crc32_fcs_stream: four instances cover 1/2/4-byte APPEND and 1-byte CHECK.
// Stimulus pushes expected beats and CRC results; a negedge monitor pops and compares.
module tb_crc32_fcs_stream;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0] v;
    logic        e;
    logic        chk;
  } crcx_t;

  typedef logic [7:0] bq_t [$];

  logic        clk;
  logic        rst;
  logic [3:0]  clr, sv, sl, rdy, mv, ml, mr, cv, ce;
  logic [31:0] sd [4];
  logic [3:0]  sk [4];
  logic [31:0] md [4];
  logic [3:0]  mk [4];
  logic [31:0] co [4];

  beat_t exp_q [4][$];
  crcx_t crc_q [4][$];
  logic  hold_v [4];
  beat_t hold_b [4];

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: 1-byte APPEND, 1: 1-byte CHECK, 2: 4-byte APPEND, 3: 2-byte APPEND
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int B = (g == 2) ? 4 : (g == 3) ? 2 : 1;
    localparam bit M = (g == 1);
    logic [8*B-1:0] m_data_w;
    logic [B-1:0]   m_keep_w;
    crc32_fcs_stream #(.BYTES(B), .MODE(M)) dut (
      .clk(clk), .rst(rst), .crc_clr(clr[g]),
      .s_data(sd[g][8*B-1:0]), .s_keep(sk[g][B-1:0]), .s_valid(sv[g]), .s_last(sl[g]),
      .s_ready(rdy[g]),
      .m_data(m_data_w), .m_keep(m_keep_w), .m_valid(mv[g]), .m_last(ml[g]), .m_ready(mr[g]),
      .crc_out(co[g]), .crc_valid(cv[g]), .crc_err(ce[g])
    );
    assign md[g] = 32'(m_data_w);
    assign mk[g] = 4'(m_keep_w);
  end

  function automatic int nb(input int k);
    return (k == 2) ? 4 : (k == 3) ? 2 : 1;
  endfunction

  always @(negedge clk) begin
    beat_t b;
    crcx_t c;
    for (int k = 0; k < 4; k++) begin
      if (hold_v[k] && mv[k]) begin
        checks++;
        if ({md[k], mk[k], ml[k]} != hold_b[k]) begin
          errors++;
          $display("FAIL hold[%0d] got %h/%h/%b required %h/%h/%b", k, md[k], mk[k], ml[k],
                   hold_b[k].d, hold_b[k].k, hold_b[k].l);
        end
      end
      hold_v[k] = mv[k] && !mr[k];
      hold_b[k] = {md[k], mk[k], ml[k]};
      if (mv[k] && mr[k]) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL beat[%0d] unexpected d=%h k=%h l=%b", k, md[k], mk[k], ml[k]);
        end else begin
          b = exp_q[k].pop_front();
          if (md[k] != b.d || mk[k] != b.k || ml[k] != b.l) begin
            errors++;
            $display("FAIL beat[%0d] got d=%h k=%h l=%b required d=%h k=%h l=%b", k,
                     md[k], mk[k], ml[k], b.d, b.k, b.l);
          end
        end
      end
      if (cv[k]) begin
        checks++;
        if (crc_q[k].size() == 0) begin
          errors++;
          $display("FAIL crc[%0d] unexpected crc_valid crc_out=%h", k, co[k]);
        end else begin
          c = crc_q[k].pop_front();
          if ((c.chk && co[k] != c.v) || ce[k] != c.e) begin
            errors++;
            $display("FAIL crc[%0d] got crc_out=%h err=%b required crc_out=%h err=%b", k,
                     co[k], ce[k], c.v, c.e);
          end
        end
      end
    end
  end

  task automatic expect_crc(input int k, input logic [31:0] v, input logic e, input logic chk);
    crcx_t c;
    c.v = v; c.e = e; c.chk = chk;
    crc_q[k].push_back(c);
  endtask

  task automatic send_beat(input int k, input logic [31:0] d, input logic [3:0] keep,
                           input logic last);
    beat_t e;
    int    n;
    e.d = d;
    e.k = last ? keep : 4'((1 << nb(k)) - 1);
    e.l = (k == 1) ? last : 1'b0;
    exp_q[k].push_back(e);
    sd[k] = d; sk[k] = keep; sl[k] = last; sv[k] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy[k] && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!rdy[k]) begin
      errors++;
      $display("FAIL accept[%0d] timeout s_ready=%b required 1", k, rdy[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_fcs(input int k, input logic [31:0] fcs);
    beat_t       e;
    logic [31:0] m;
    int          n;
    n = 4 / nb(k);
    m = (nb(k) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb(k))) - 32'd1);
    for (int i = 0; i < n; i++) begin
      e.d = (fcs >> (8 * nb(k) * i)) & m;
      e.k = 4'((1 << nb(k)) - 1);
      e.l = (i == n - 1);
      exp_q[k].push_back(e);
    end
  endtask

  task automatic send_b1_frame(input int k, input bq_t b, input logic drop);
    for (int i = 0; i < b.size(); i++)
      send_beat(k, 32'(b[i]), 4'h1, (i == b.size() - 1));
    if (drop) sv[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0 || crc_q[k].size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q[k].size() != 0 || crc_q[k].size() != 0) begin
      errors++;
      $display("FAIL drain[%0d] pending beats=%0d crcs=%0d required 0", k,
               exp_q[k].size(), crc_q[k].size());
    end
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  initial begin
    bq_t q, qf, qb, qz;
    rst = 1'b1; clr = '0; sv = '0; sl = '0; mr = 4'hF;
    for (int k = 0; k < 4; k++) begin
      sd[k] = '0; sk[k] = '0; hold_v[k] = 1'b0; hold_b[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check1($sformatf("rst_m_valid[%0d]", k), 32'(mv[k]), 32'd0);
      check1($sformatf("rst_m_last[%0d]", k), 32'(ml[k]), 32'd0);
      check1($sformatf("rst_crc_valid[%0d]", k), 32'(cv[k]), 32'd0);
      check1($sformatf("rst_crc_err[%0d]", k), 32'(ce[k]), 32'd0);
      check1($sformatf("rst_crc_out[%0d]", k), co[k], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    q  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    qf = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    qb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h34, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    qz = '{8'h00};

    // 1-byte APPEND check string
    expect_crc(0, 32'hCBF4_3926, 1'b0, 1'b1);
    send_b1_frame(0, q, 1'b1);
    push_fcs(0, 32'hCBF4_3926);
    drain(0);

    // CHECK mode: good frame, then one corrupted byte
    expect_crc(1, 32'h2144_DF1C, 1'b0, 1'b1);
    send_b1_frame(1, qf, 1'b1);
    expect_crc(1, 32'h0, 1'b1, 1'b0);
    send_b1_frame(1, qb, 1'b1);
    drain(1);

    // 4-byte APPEND with a partial last beat
    expect_crc(2, 32'hCBF4_3926, 1'b0, 1'b1);
    send_beat(2, 32'h3433_3231, 4'hF, 1'b0);
    send_beat(2, 32'h3837_3635, 4'hF, 1'b0);
    send_beat(2, 32'h0000_0039, 4'h1, 1'b1);
    sv[2] = 1'b0;
    push_fcs(2, 32'hCBF4_3926);
    drain(2);

    // 2-byte APPEND, single zero byte, toggling backpressure
    expect_crc(3, 32'hD202_EF8D, 1'b0, 1'b1);
    fork
      begin
        send_beat(3, 32'h0, 4'h1, 1'b1);
        sv[3] = 1'b0;
        push_fcs(3, 32'hD202_EF8D);
      end
      begin
        repeat (24) begin
          @(posedge clk);
          #1;
          mr[3] = ~mr[3];
        end
        mr[3] = 1'b1;
      end
    join
    drain(3);

    // reset while a beat is held on the output
    send_beat(0, 32'h31, 4'h1, 1'b0);
    send_beat(0, 32'h32, 4'h1, 1'b0);
    send_beat(0, 32'h33, 4'h1, 1'b0);
    sv[0] = 1'b0;
    mr[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("rst_mid_m_valid", 32'(mv[0]), 32'd0);
    rst = 1'b0;
    mr[0] = 1'b1;
    exp_q[0].delete();
    expect_crc(0, 32'hCBF4_3926, 1'b0, 1'b1);
    send_b1_frame(0, q, 1'b1);
    push_fcs(0, 32'hCBF4_3926);
    drain(0);

    // crc_clr abandons a partial frame
    send_beat(0, 32'h31, 4'h1, 1'b0);
    send_beat(0, 32'h32, 4'h1, 1'b0);
    sv[0] = 1'b0;
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    expect_crc(0, 32'hCBF4_3926, 1'b0, 1'b1);
    send_b1_frame(0, q, 1'b1);
    push_fcs(0, 32'hCBF4_3926);
    drain(0);

    // back-to-back frames with s_valid held high
    stalls = 0;
    expect_crc(0, 32'hCBF4_3926, 1'b0, 1'b1);
    expect_crc(0, 32'hD202_EF8D, 1'b0, 1'b1);
    send_b1_frame(0, q, 1'b0);
    push_fcs(0, 32'hCBF4_3926);
    send_b1_frame(0, qz, 1'b1);
    push_fcs(0, 32'hD202_EF8D);
    drain(0);
    check1("b2b_stall_cycles", 32'(stalls), 32'd4);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc32_fcs_stream.md
Name: crc32_fcs_stream

Overview:
Parametrised streaming Ethernet CRC-32 engine, processing BYTES bytes per clock through a valid/ready handshake. In APPEND mode (TX) it forwards the frame and then emits the 4-byte FCS as extra beats. In CHECK mode (RX) it forwards the frame including its received FCS and flags a residue mismatch on the last beat. It sits between the MAC framer/deframer and the GMII/RGMII byte interface, next to the ARP/UDP paths.

Parameters:
BYTES, 1, bytes per beat; legal values 1, 2, 4.
MODE, 0, 0 = APPEND (TX), 1 = CHECK (RX).
INIT, 32'hFFFFFFFF, CRC register value at reset, on crc_clr, and after each frame.
XOROUT, 32'hFFFFFFFF, XOR applied to the reflected register to form crc_out.
RESIDUE, 32'hC704DD7B, good-frame value of the internal (MSB-first) register in CHECK mode.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
crc_clr  in  1  synchronous abort: clears the CRC and returns the FSM to IDLE.
s_data  in  8*BYTES  input beat; lane 0 = bits [7:0] = first byte on the wire.
s_keep  in  BYTES  valid lanes; sampled only when s_last=1; must be contiguous from lane 0.
s_valid  in  1  input beat valid.
s_last  in  1  last beat of the frame.
s_ready  out  1  input can accept a beat.
m_data  out  8*BYTES  output beat.
m_keep  out  BYTES  output lane valids.
m_valid  out  1  output beat valid.
m_last  out  1  last output beat of the frame.
m_ready  in  1  downstream accept.
crc_out  out  32  final FCS value, held until the next frame ends.
crc_valid  out  1  one-cycle pulse when crc_out/crc_err update.
crc_err  out  1  CHECK mode: residue mismatch; held until the next crc_valid. Tied 0 in APPEND mode.

Behaviour:
- Reset (rst=1): crc_reg=INIT; FSM=IDLE; m_valid=0, m_last=0, m_data=0, m_keep=0; crc_out=0, crc_valid=0, crc_err=0. Any frame in flight is discarded.
- CRC core: 802.3 polynomial 0x04C11DB7. Each byte is bit-reversed before entry. Internal register is MSB-first.
  - Per accepted beat, BYTES byte steps are chained combinationally in lane order. Only lanes with keep=1 are included on a last beat; non-last beats use all lanes.
  - crc_out = bitreverse(crc_reg_final) ^ XOROUT.
- Handshake: a beat is accepted when s_valid && s_ready.
  - s_ready = (!m_valid || m_ready) && state != FCS.
  - Output register; latency is 1 cycle from acceptance to m_valid.
  - While m_valid && !m_ready, m_* are held stable.
- FSM states: IDLE/DATA (pass-through) and FCS (APPEND only).
- APPEND mode:
  - On the last beat accepted: forward it with m_last=0 and its own keep. Latch fcs = crc_out of the next-state CRC. Pulse crc_valid next cycle. Set crc_reg=INIT. Go to FCS with cnt = 4/BYTES - 1.
  - In FCS: emit fcs as 4/BYTES beats, LSB byte first, m_keep all ones. m_last=1 on the final beat. Each beat advances on m_ready. After the final beat, return to IDLE.
  - FCS is never packed into a partial last data beat.
- CHECK mode:
  - All beats, FCS included, pass through unchanged with m_last.
  - On the last beat accepted: crc_err = (next-state crc_reg != RESIDUE). crc_out = received-frame CRC. crc_valid pulses next cycle. crc_reg=INIT.
- s_last with s_keep=0: no CRC update for that beat; it completes the frame as above. In APPEND mode the beat is still forwarded with m_keep=0.
- crc_clr:
  - Has priority over a same-cycle accepted beat for crc_reg; the beat is still forwarded.
  - In FCS state it drops the remaining FCS beats; the current m_* beat completes.
- Back-to-back frames: a new frame starts from INIT with no idle cycle required, except that APPEND mode blocks input during FCS.

Test Plan:
1. BYTES=1, APPEND, "123456789" (0x31..0x39), m_ready=1 -> m bytes 31..39 then 26,39,F4,CB; m_last on 0xCB; crc_out=0xCBF43926 with one crc_valid pulse.
2. BYTES=1, CHECK, "123456789"+26,39,F4,CB -> crc_err=0. Same frame with byte 0x35 flipped to 0x34 -> crc_err=1.
3. BYTES=4, APPEND, beats 0x34333231, 0x38373635, 0x00000039 with keep=0001 on the last beat -> three data beats, then FCS beat 0xCBF43926 with m_keep=1111 and m_last=1.
4. BYTES=2, APPEND, single byte 0x00 (keep=01) -> FCS beats 0xEF8D, then 0xD202; crc_out=0xD202EF8D. m_ready toggling 1/0 each cycle -> outputs held stable and no byte lost or duplicated.
5. rst asserted mid-frame after 3 bytes, then "123456789" sent -> m_valid=0 the cycle after rst; the following frame's crc_out=0xCBF43926.
6. Back-to-back frames "123456789" then single byte 0x00 with s_valid held high -> crc_out=0xCBF43926, then 0xD202EF8D; s_ready=0 only during the FCS beats.
